// File: rtl/cpu_pkg.sv
// Shared CPU types: NOP encoding, fetch/load state enum and boot image.
package cpu_pkg;

  localparam logic [31:0] NOP = '0;

  typedef enum logic {
    RUN,
    LOAD
  } state_t;

  // Words 0x05..0x13 share the same encoding; everything past 0x13 is NOP.
  function automatic logic [31:0] boot_word(input int unsigned idx);
    logic [31:0] w;
    w = NOP;
    case (idx)
      1: w = 32'h0010_1464;
      2: w = 32'h4000_0422;
      3: w = 32'h3400_0489;
      4: w = 32'h3C00_0C27;
      default:
        if (idx >= 5 && idx <= 19)
          w = 32'h4800_0001;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/inst_mem_load_ctrl.sv
// Load-mode FSM for the instruction memory: handshake, word count, range error.
module inst_mem_load_ctrl
  import cpu_pkg::*;
#(
  parameter int ADDR_W = 6,
  parameter int DEPTH  = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ld_start,
  input  logic              ld_valid,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic              ld_last,
  output state_t            state,
  output logic              ld_ready,
  output logic              ld_busy,
  output logic [ADDR_W:0]   ld_count,
  output logic              ld_err,
  output logic              wr_en
);

  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

  logic accept;
  logic in_range;

  assign accept   = (state == LOAD) && ld_valid && ld_ready;
  assign in_range = {1'b0, ld_addr} < DEPTH_C;
  assign wr_en    = accept && in_range;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= RUN;
      ld_ready <= 1'b0;
      ld_busy  <= 1'b0;
      ld_count <= '0;
      ld_err   <= 1'b0;
    end else begin
      unique case (state)
        RUN: begin
          if (ld_start) begin
            state    <= LOAD;
            ld_ready <= 1'b1;
            ld_busy  <= 1'b1;
            ld_count <= '0;
            ld_err   <= 1'b0;
          end
        end
        LOAD: begin
          if (accept) begin
            if (in_range && ld_count < DEPTH_C)
              ld_count <= ld_count + 1'b1;
            if (!in_range)
              ld_err <= 1'b1;
            if (ld_last) begin
              state    <= RUN;
              ld_ready <= 1'b0;
              ld_busy  <= 1'b0;
            end
          end
        end
        default: state <= RUN;
      endcase
    end
  end

endmodule

// File: rtl/inst_mem_sync.sv
// Registered-read instruction memory with stall/flush and optional run-time
// program loading (build with IMEM_LOAD_EN to enable the load port).
module inst_mem_sync
  import cpu_pkg::*;
#(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] a,
  input  logic              en,
  input  logic              flush,
  output logic [DATA_W-1:0] inst,
  output logic              inst_valid,
  input  logic              ld_start,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              ld_last,
  output logic              ld_busy,
  output logic [ADDR_W:0]   ld_count,
  output logic              ld_err
);

  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);
  localparam logic [DATA_W-1:0] NOP_W = DATA_W'(NOP);

  logic              a_ok;
  logic              loading;
  logic [DATA_W-1:0] rd;

  assign a_ok = {1'b0, a} < DEPTH_C;

`ifdef IMEM_LOAD_EN
  typedef logic [DATA_W-1:0] img_t [DEPTH];

  function automatic img_t boot_img();
    img_t m;
    for (int i = 0; i < DEPTH; i++)
      m[i] = DATA_W'(boot_word(i));
    return m;
  endfunction

  // Array is never reset; contents survive a reset taken mid-load.
  img_t   mem = boot_img();
  state_t state;
  logic   wr_en;

  inst_mem_load_ctrl #(
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_ctrl (
    .clk      (clk),
    .rst_n    (rst_n),
    .ld_start (ld_start),
    .ld_valid (ld_valid),
    .ld_addr  (ld_addr),
    .ld_last  (ld_last),
    .state    (state),
    .ld_ready (ld_ready),
    .ld_busy  (ld_busy),
    .ld_count (ld_count),
    .ld_err   (ld_err),
    .wr_en    (wr_en)
  );

  always_ff @(posedge clk)
    if (wr_en)
      mem[ld_addr] <= ld_data;

  assign loading = (state == LOAD);
  assign rd      = a_ok ? mem[a] : NOP_W;
`else
  logic unused_ld;

  assign unused_ld = ^{ld_start, ld_valid, ld_addr, ld_data, ld_last};
  assign ld_ready  = 1'b0;
  assign ld_busy   = 1'b0;
  assign ld_count  = '0;
  assign ld_err    = 1'b0;
  assign loading   = 1'b0;
  assign rd        = a_ok ? DATA_W'(boot_word(32'(a))) : NOP_W;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inst       <= NOP_W;
      inst_valid <= 1'b0;
    end else if (loading || flush) begin
      inst       <= NOP_W;
      inst_valid <= 1'b0;
    end else if (en) begin
      inst       <= rd;
      inst_valid <= 1'b1;
    end
  end

endmodule

// File: tb/tb_inst_mem_sync.sv
// Directed bench for inst_mem_sync: fetch scoreboard plus load-port checks.
module tb_inst_mem_sync;

  localparam int ADDR_W = 6;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 48;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [ADDR_W-1:0] a;
  logic              en;
  logic              flush;
  logic [DATA_W-1:0] inst;
  logic              inst_valid;
  logic              ld_start;
  logic              ld_valid;
  logic              ld_ready;
  logic [ADDR_W-1:0] ld_addr;
  logic [DATA_W-1:0] ld_data;
  logic              ld_last;
  logic              ld_busy;
  logic [ADDR_W:0]   ld_count;
  logic              ld_err;

  int checks = 0;
  int errors = 0;

  logic [DATA_W:0] sb [$];

  inst_mem_sync #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .a          (a),
    .en         (en),
    .flush      (flush),
    .inst       (inst),
    .inst_valid (inst_valid),
    .ld_start   (ld_start),
    .ld_valid   (ld_valid),
    .ld_ready   (ld_ready),
    .ld_addr    (ld_addr),
    .ld_data    (ld_data),
    .ld_last    (ld_last),
    .ld_busy    (ld_busy),
    .ld_count   (ld_count),
    .ld_err     (ld_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Push expected fetch result, clock once, pop and compare.
  task automatic step(input string tag, input logic [DATA_W-1:0] ei,
                      input logic ev);
    logic [DATA_W:0] e;
    sb.push_back({ev, ei});
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk({tag, ".inst"}, 64'(inst), 64'(e[DATA_W-1:0]));
    chk({tag, ".valid"}, 64'(inst_valid), 64'(e[DATA_W]));
  endtask

  task automatic chk_ld(input string tag, input logic er, input logic eb,
                        input int ec, input logic ee);
    chk({tag, ".ready"}, 64'(ld_ready), 64'(er));
    chk({tag, ".busy"}, 64'(ld_busy), 64'(eb));
    chk({tag, ".count"}, 64'(ld_count), 64'(ec));
    chk({tag, ".err"}, 64'(ld_err), 64'(ee));
  endtask

  initial begin
    rst_n = 1'b0; a = '0; en = 1'b0; flush = 1'b0;
    ld_start = 1'b0; ld_valid = 1'b0; ld_addr = '0;
    ld_data = '0; ld_last = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.inst", 64'(inst), 64'h0);
    chk("rst.valid", 64'(inst_valid), 64'h0);
    chk_ld("rst", 1'b0, 1'b0, 0, 1'b0);

    rst_n = 1'b1; en = 1'b1; a = 6'h01;
    step("f01", 32'h0010_1464, 1'b1);
    a = 6'h04;
    step("f04", 32'h3C00_0C27, 1'b1);
    a = 6'h05; en = 1'b0;
    step("stall", 32'h3C00_0C27, 1'b1);
    flush = 1'b1;
    step("flush", 32'h0, 1'b0);
    flush = 1'b0; en = 1'b1; a = 6'h3F;
    step("oob", 32'h0, 1'b1);
    a = 6'h13;
    step("f13", 32'h4800_0001, 1'b1);
    a = 6'h14;
    step("f14", 32'h0, 1'b1);
    a = 6'h02; flush = 1'b1;
    step("flush_en", 32'h0, 1'b0);
    flush = 1'b0;
    step("f02", 32'h4000_0422, 1'b1);

`ifdef IMEM_LOAD_EN
    a = 6'h00; ld_start = 1'b1;
    step("ldst", 32'h0, 1'b1);
    chk_ld("ldst", 1'b1, 1'b1, 0, 1'b0);
    ld_start = 1'b0; a = 6'h01;
    ld_valid = 1'b1; ld_addr = 6'h00; ld_data = 32'h0010_0421;
    step("ldw0", 32'h0, 1'b0);
    chk_ld("ldw0", 1'b1, 1'b1, 1, 1'b0);
    ld_addr = 6'h01; ld_data = 32'h0420_0823; ld_last = 1'b1;
    step("ldw1", 32'h0, 1'b0);
    chk_ld("ldw1", 1'b0, 1'b0, 2, 1'b0);
    ld_valid = 1'b0; ld_last = 1'b0;
    step("new01", 32'h0420_0823, 1'b1);
    a = 6'h00;
    step("new00", 32'h0010_0421, 1'b1);

    a = 6'h01; ld_start = 1'b1;
    step("ld2st", 32'h0420_0823, 1'b1);
    chk_ld("ld2st", 1'b1, 1'b1, 0, 1'b0);
    ld_start = 1'b0; ld_valid = 1'b1; ld_addr = 6'h3F;
    ld_data = 32'hBAD0_BAD0;
    step("ldoob", 32'h0, 1'b0);
    chk_ld("ldoob", 1'b1, 1'b1, 0, 1'b1);
    ld_addr = 6'h05; ld_data = 32'h1111_2222; ld_last = 1'b1;
    step("ldw5", 32'h0, 1'b0);
    chk_ld("ldw5", 1'b0, 1'b0, 1, 1'b1);
    ld_valid = 1'b0; ld_last = 1'b0; a = 6'h05; ld_start = 1'b1;
    step("ld3st", 32'h1111_2222, 1'b1);
    chk_ld("ld3st", 1'b1, 1'b1, 0, 1'b0);
    ld_start = 1'b0; ld_valid = 1'b1; ld_addr = 6'h06;
    ld_data = 32'hDEAD_BEEF;
    step("ldw6", 32'h0, 1'b0);
    chk_ld("ldw6", 1'b1, 1'b1, 1, 1'b0);
    ld_valid = 1'b0; rst_n = 1'b0;
    #1;
    chk("midrst.inst", 64'(inst), 64'h0);
    chk("midrst.valid", 64'(inst_valid), 64'h0);
    chk_ld("midrst", 1'b0, 1'b0, 0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1; a = 6'h06;
    step("kept06", 32'hDEAD_BEEF, 1'b1);
    a = 6'h05;
    step("kept05", 32'h1111_2222, 1'b1);
`else
    a = 6'h01; ld_start = 1'b1;
    step("rom_st", 32'h0010_1464, 1'b1);
    chk_ld("rom_st", 1'b0, 1'b0, 0, 1'b0);
    ld_start = 1'b0; ld_valid = 1'b1; ld_addr = 6'h01;
    ld_data = 32'hFFFF_FFFF; ld_last = 1'b1;
    step("rom_w", 32'h0010_1464, 1'b1);
    chk_ld("rom_w", 1'b0, 1'b0, 0, 1'b0);
    ld_valid = 1'b0; ld_last = 1'b0;
    step("rom_rd", 32'h0010_1464, 1'b1);
    a = 6'h03;
    step("rom_03", 32'h3400_0489, 1'b1);
`endif

    if (sb.size() != 0) begin
      errors++;
      $error("FAIL scoreboard: %0d left, expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
